// File: rtl/dither_sequencer.sv
// Address/phase sequencer for error-diffusion dithering: load, per-pixel/per-channel process, unload.
// Outputs are combinational from state/counters (done also qualified by mcu_rx_ack); stalls on mcu_tx_rdy / mcu_rx_ack.
module dither_sequencer #(
    parameter int IMAGEX     = 64,
    parameter int IMAGEY     = 64,
    parameter int CHANNELS   = 1,
    parameter int SERPENTINE = 0,
    localparam int ADDR_W    = $clog2(IMAGEX * IMAGEY),
    localparam int XW        = $clog2(IMAGEX),
    localparam int YW        = $clog2(IMAGEY),
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mcu_tx_rdy,
    input  logic              mcu_rx_ack,
    output logic [ADDR_W-1:0] png_idx,
    output logic [XW-1:0]     x_pos,
    output logic [YW-1:0]     y_pos,
    output logic [CW-1:0]     chan_idx,
    output logic              rden,
    output logic              wren,
    output logic              store_old_p,
    output logic              compare_and_store_n,
    output logic [3:0]        compute_fin,
    output logic              mcu_rx_rdy,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        P_OLD,
        P_CMP,
        P_E,
        P_SW,
        P_S,
        P_SE,
        UNLOAD
    } state_t;

    localparam logic [XW-1:0] X_MAX = XW'(IMAGEX - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMAGEY - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   chan_q, chan_d;

    logic            rev;
    logic            ahead_ok;
    logic            behind_ok;
    logic            down_ok;
    logic            row_end;
    logic            last_raster;
    logic [3:0]      nb_vld;
    logic [3:0]      rem;
    logic            phase_adv;

    // "ahead" is the scan direction; on reverse rows the x offsets flip.
    assign rev         = (SERPENTINE != 0) && y_q[0];
    assign ahead_ok    = rev ? (x_q != '0) : (x_q != X_MAX);
    assign behind_ok   = rev ? (x_q != X_MAX) : (x_q != '0);
    assign down_ok     = (y_q != Y_MAX);
    assign nb_vld      = {ahead_ok & down_ok, down_ok, behind_ok & down_ok, ahead_ok};
    assign row_end     = rev ? (x_q == '0) : (x_q == X_MAX);
    assign last_raster = (x_q == X_MAX) && (y_q == Y_MAX);

    assign png_idx  = ADDR_W'(int'(y_q) * IMAGEX + int'(x_q));
    assign x_pos    = x_q;
    assign y_pos    = y_q;
    assign chan_idx = chan_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            chan_q  <= chan_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        x_d                 = x_q;
        y_d                 = y_q;
        chan_d              = chan_q;
        rden                = 1'b0;
        wren                = 1'b0;
        store_old_p         = 1'b0;
        compare_and_store_n = 1'b0;
        compute_fin         = 4'b0000;
        mcu_rx_rdy          = 1'b0;
        done                = 1'b0;
        rem                 = 4'b0000;
        phase_adv           = 1'b0;

        case (state_q)
            IDLE: begin
                if (mcu_tx_rdy) begin
                    state_d = LOAD;
                    x_d     = '0;
                    y_d     = '0;
                    chan_d  = '0;
                end
            end
            LOAD: begin
                if (mcu_tx_rdy) begin
                    wren = 1'b1;
                    if (last_raster) begin
                        state_d = P_OLD;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            P_OLD: begin
                rden        = 1'b1;
                store_old_p = 1'b1;
                state_d     = P_CMP;
            end
            P_CMP: begin
                wren                = 1'b1;
                compare_and_store_n = 1'b1;
                rem                 = nb_vld;
                phase_adv           = 1'b1;
            end
            P_E: begin
                compute_fin[0] = 1'b1;
                rem            = nb_vld & 4'b1110;
                phase_adv      = 1'b1;
            end
            P_SW: begin
                compute_fin[1] = 1'b1;
                rem            = nb_vld & 4'b1100;
                phase_adv      = 1'b1;
            end
            P_S: begin
                compute_fin[2] = 1'b1;
                rem            = nb_vld & 4'b1000;
                phase_adv      = 1'b1;
            end
            P_SE: begin
                compute_fin[3] = 1'b1;
                phase_adv      = 1'b1;
            end
            UNLOAD: begin
                rden       = 1'b1;
                mcu_rx_rdy = 1'b1;
                if (mcu_rx_ack) begin
                    if (last_raster) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Jump straight to the next in-image neighbour; out-of-image phases cost no cycle.
        if (phase_adv) begin
            if (rem[0]) begin
                state_d = P_E;
            end else if (rem[1]) begin
                state_d = P_SW;
            end else if (rem[2]) begin
                state_d = P_S;
            end else if (rem[3]) begin
                state_d = P_SE;
            end else if (chan_q != C_MAX) begin
                chan_d  = chan_q + CW'(1);
                state_d = P_OLD;
            end else begin
                chan_d = '0;
                if (row_end && (y_q == Y_MAX)) begin
                    state_d = UNLOAD;
                    x_d     = '0;
                    y_d     = '0;
                end else if (row_end) begin
                    state_d = P_OLD;
                    y_d     = y_q + YW'(1);
                    // The new row is odd exactly when the current one is even.
                    x_d     = ((SERPENTINE != 0) && !y_q[0]) ? X_MAX : '0;
                end else begin
                    state_d = P_OLD;
                    x_d     = rev ? (x_q - XW'(1)) : (x_q + XW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_dither_sequencer.sv
// Directed bench for dither_sequencer: four instances share stimulus, each test resets and watches one.
module tb_dither_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic tx_rdy = 1'b0;
    logic rx_ack = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] O  = 6'b100000;
    localparam logic [5:0] C  = 6'b010000;
    localparam logic [5:0] E  = 6'b000001;
    localparam logic [5:0] SW = 6'b000010;
    localparam logic [5:0] S  = 6'b000100;
    localparam logic [5:0] SE = 6'b001000;

    // 2x2 forward scan, hand-derived neighbour phases per pixel
    localparam logic [5:0] SEQ2 [14] = '{O, C, E, S, SE, O, C, SW, S, O, C, E, O, C};
    localparam int PIX2 [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3};
    localparam int PST2 [5]  = '{0, 5, 9, 12, 14};

    // 4x2 serpentine: row 0 forward, row 1 reverse (last row: only E toward lower x)
    localparam logic [5:0] SEQS [32] = '{
        O, C, E, S, SE,
        O, C, E, SW, S, SE,
        O, C, E, SW, S, SE,
        O, C, SW, S,
        O, C, E,
        O, C, E,
        O, C, E,
        O, C};
    localparam int XS [32] = '{0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 3,3,3,3,
                               3,3,3, 2,2,2, 1,1,1, 0,0};
    localparam int YS [32] = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,
                               1,1,1, 1,1,1, 1,1,1, 1,1};

    // Instance A: 2x2, 1 channel
    logic [1:0] a_idx; logic [0:0] a_x, a_y, a_ch; logic [3:0] a_fin;
    logic a_rden, a_wren, a_old, a_cmp, a_rxrdy, a_busy, a_done;
    dither_sequencer #(.IMAGEX(2), .IMAGEY(2), .CHANNELS(1), .SERPENTINE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .mcu_tx_rdy(tx_rdy), .mcu_rx_ack(rx_ack),
        .png_idx(a_idx), .x_pos(a_x), .y_pos(a_y), .chan_idx(a_ch),
        .rden(a_rden), .wren(a_wren), .store_old_p(a_old), .compare_and_store_n(a_cmp),
        .compute_fin(a_fin), .mcu_rx_rdy(a_rxrdy), .busy(a_busy), .done(a_done));

    // Instance B: 2x2, 3 channels
    logic [1:0] b_idx; logic [0:0] b_x, b_y; logic [1:0] b_ch; logic [3:0] b_fin;
    logic b_rden, b_wren, b_old, b_cmp, b_rxrdy, b_busy, b_done;
    dither_sequencer #(.IMAGEX(2), .IMAGEY(2), .CHANNELS(3), .SERPENTINE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .mcu_tx_rdy(tx_rdy), .mcu_rx_ack(rx_ack),
        .png_idx(b_idx), .x_pos(b_x), .y_pos(b_y), .chan_idx(b_ch),
        .rden(b_rden), .wren(b_wren), .store_old_p(b_old), .compare_and_store_n(b_cmp),
        .compute_fin(b_fin), .mcu_rx_rdy(b_rxrdy), .busy(b_busy), .done(b_done));

    // Instance C: 4x2 serpentine
    logic [2:0] c_idx; logic [1:0] c_x; logic [0:0] c_y, c_ch; logic [3:0] c_fin;
    logic c_rden, c_wren, c_old, c_cmp, c_rxrdy, c_busy, c_done;
    dither_sequencer #(.IMAGEX(4), .IMAGEY(2), .CHANNELS(1), .SERPENTINE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .mcu_tx_rdy(tx_rdy), .mcu_rx_ack(rx_ack),
        .png_idx(c_idx), .x_pos(c_x), .y_pos(c_y), .chan_idx(c_ch),
        .rden(c_rden), .wren(c_wren), .store_old_p(c_old), .compare_and_store_n(c_cmp),
        .compute_fin(c_fin), .mcu_rx_rdy(c_rxrdy), .busy(c_busy), .done(c_done));

    // Instance D: 3x3 forward, used for mid-process reset
    logic [3:0] d_idx; logic [1:0] d_x, d_y; logic [0:0] d_ch; logic [3:0] d_fin;
    logic d_rden, d_wren, d_old, d_cmp, d_rxrdy, d_busy, d_done;
    dither_sequencer #(.IMAGEX(3), .IMAGEY(3), .CHANNELS(1), .SERPENTINE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .mcu_tx_rdy(tx_rdy), .mcu_rx_ack(rx_ack),
        .png_idx(d_idx), .x_pos(d_x), .y_pos(d_y), .chan_idx(d_ch),
        .rden(d_rden), .wren(d_wren), .store_old_p(d_old), .compare_and_store_n(d_cmp),
        .compute_fin(d_fin), .mcu_rx_rdy(d_rxrdy), .busy(d_busy), .done(d_done));

    wire [19:0] a_all = {a_idx, a_x, a_y, a_ch, a_rden, a_wren, a_old, a_cmp, a_fin,
                         a_rxrdy, a_busy, a_done, 4'b0};
    wire [22:0] d_all = {d_idx, d_x, d_y, d_ch, d_rden, d_wren, d_old, d_cmp, d_fin,
                         d_rxrdy, d_busy, d_done, 2'b0};

    task automatic do_reset();
        rst_n  = 1'b0;
        tx_rdy = 1'b0;
        rx_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle framing: inputs change 1 after the rising edge, outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if (a_all !== 20'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", a_all);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_busy !== 1'b0 || a_wren !== 1'b0) begin
                n_fail++; $display("FAIL idle_wait[%0d]: busy=%b wren=%b want 0 0", i, a_busy, a_wren);
            end
            next_cycle();
        end
    endtask

    task automatic test_full_flow();
        do_reset();
        tx_rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_before_load: busy=%b want 0", a_busy);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            n_chk++;
            if (a_wren !== 1'b1 || a_idx !== 2'(i) || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL load_cont[%0d]: wren=%b idx=%0d busy=%b want 1 %0d 1",
                                   i, a_wren, a_idx, a_busy, i);
            end
        end
        // tx_rdy stays high during processing and must be ignored
        for (int k = 0; k < 14; k++) begin
            next_cycle();
            @(negedge clk);
            n_chk++;
            if ({a_old, a_cmp, a_fin} !== SEQ2[k] || a_idx !== 2'(PIX2[k])) begin
                n_fail++; $display("FAIL proc2x2[%0d]: phase=%b idx=%0d want %b %0d",
                                   k, {a_old, a_cmp, a_fin}, a_idx, SEQ2[k], PIX2[k]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            tx_rdy = 1'b0;
            rx_ack = 1'b0;
            @(negedge clk);
            n_chk++;
            if (a_rxrdy !== 1'b1 || a_rden !== 1'b1 || a_idx !== 2'd0 || a_done !== 1'b0) begin
                n_fail++; $display("FAIL unload_hold[%0d]: rxrdy=%b rden=%b idx=%0d done=%b want 1 1 0 0",
                                   i, a_rxrdy, a_rden, a_idx, a_done);
            end
        end
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            rx_ack = 1'b1;
            @(negedge clk);
            n_chk++;
            if (a_idx !== 2'(j) || a_rxrdy !== 1'b1 || a_done !== (j == 3)) begin
                n_fail++; $display("FAIL unload_ack[%0d]: idx=%0d rxrdy=%b done=%b want %0d 1 %0d",
                                   j, a_idx, a_rxrdy, a_done, j, (j == 3));
            end
        end
        next_cycle();
        rx_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rxrdy !== 1'b0) begin
            n_fail++; $display("FAIL after_done: busy=%b done=%b rxrdy=%b want 0 0 0", a_busy, a_done, a_rxrdy);
        end
    endtask

    task automatic test_load_stall();
        int exp_idx;
        do_reset();
        tx_rdy = 1'b1;
        exp_idx = 0;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            tx_rdy = (i % 2 == 0);
            @(negedge clk);
            n_chk++;
            if (a_wren !== tx_rdy || a_idx !== 2'(exp_idx)) begin
                n_fail++; $display("FAIL load_stall[%0d]: wren=%b idx=%0d want %b %0d",
                                   i, a_wren, a_idx, tx_rdy, exp_idx);
            end
            if (tx_rdy) exp_idx++;
        end
        next_cycle();
        tx_rdy = 1'b0;
        @(negedge clk);
        n_chk++;
        if (a_old !== 1'b1 || a_idx !== 2'd0) begin
            n_fail++; $display("FAIL stall_to_proc: old=%b idx=%0d want 1 0", a_old, a_idx);
        end
    endtask

    task automatic test_channels();
        do_reset();
        tx_rdy = 1'b1;
        repeat (5) next_cycle();
        tx_rdy = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = PST2[p]; k < PST2[p+1]; k++) begin
                    @(negedge clk);
                    n_chk++;
                    if ({b_old, b_cmp, b_fin} !== SEQ2[k] || b_ch !== 2'(ch) || b_idx !== 2'(p)) begin
                        n_fail++; $display("FAIL chan3[p%0d c%0d k%0d]: phase=%b ch=%0d idx=%0d want %b %0d %0d",
                                           p, ch, k, {b_old, b_cmp, b_fin}, b_ch, b_idx, SEQ2[k], ch, p);
                    end
                    next_cycle();
                end
            end
        end
        @(negedge clk);
        n_chk++;
        if (b_rxrdy !== 1'b1 || b_idx !== 2'd0 || b_ch !== 2'd0) begin
            n_fail++; $display("FAIL chan3_unload: rxrdy=%b idx=%0d ch=%0d want 1 0 0", b_rxrdy, b_idx, b_ch);
        end
    endtask

    task automatic test_serpentine();
        do_reset();
        tx_rdy = 1'b1;
        repeat (9) next_cycle();
        tx_rdy = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_chk++;
            if ({c_old, c_cmp, c_fin} !== SEQS[k] || c_x !== 2'(XS[k]) || c_y !== 1'(YS[k])
                || c_idx !== 3'(YS[k] * 4 + XS[k])) begin
                n_fail++; $display("FAIL serp[%0d]: phase=%b x=%0d y=%0d idx=%0d want %b %0d %0d %0d",
                                   k, {c_old, c_cmp, c_fin}, c_x, c_y, c_idx,
                                   SEQS[k], XS[k], YS[k], YS[k] * 4 + XS[k]);
            end
            next_cycle();
        end
        @(negedge clk);
        n_chk++;
        if (c_rxrdy !== 1'b1 || c_idx !== 3'd0) begin
            n_fail++; $display("FAIL serp_unload: rxrdy=%b idx=%0d want 1 0", c_rxrdy, c_idx);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        tx_rdy = 1'b1;
        repeat (10) next_cycle();
        tx_rdy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (d_fin === 4'b0010 && d_x === 2'd2 && d_y === 2'd1) found = 1'b1;
            else next_cycle();
        end
        n_chk++;
        if (!found) begin
            n_fail++; $display("FAIL mid_find_sw5: P_SW of pixel 5 not reached within budget");
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (d_all !== 23'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", d_all);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (d_busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_idle[%0d]: busy=%b want 0", i, d_busy);
            end
            next_cycle();
        end
        tx_rdy = 1'b1;
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (d_wren !== 1'b1 || d_idx !== 4'd0 || d_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_restart: wren=%b idx=%0d busy=%b want 1 0 1", d_wren, d_idx, d_busy);
        end
        next_cycle();
        tx_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_flow();
        test_load_stall();
        test_channels();
        test_serpentine();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
